// File: rtl/mem_responder.sv
// mem_responder: byte-organised little-endian memory with fixed wait-state latency and one-cycle response strobe
module mem_responder #(
  parameter int DEPTH = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req,
  input  logic        mem_write,
  input  logic        byte_en,
  input  logic [15:0] address,
  input  logic [15:0] write_data,
  output logic [15:0] read_data,
  output logic        ready,
  output logic        busy,
  output logic        err
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [16:0] D = 17'(DEPTH);
  localparam logic [3:0] WL = 4'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state;
  logic [3:0] cnt;
  logic cw, cb;
  logic [15:0] ca, cd;
  logic [7:0] mem [DEPTH];
  logic w, b, e, go_resp;
  logic [15:0] a, d, rd;
  logic [AW-1:0] i0, i1;
  // With no wait states the response is formed on the accepting edge, so use live inputs in IDLE
  always_comb begin
    w = state == IDLE ? mem_write : cw;
    b = state == IDLE ? byte_en : cb;
    a = state == IDLE ? address : ca;
    d = state == IDLE ? write_data : cd;
    i0 = a[AW-1:0];
    i1 = i0 + AW'(1);
    e = (!b && a[0]) || {1'b0, a} >= D || (!b && {1'b0, a} + 17'd1 >= D);
    rd = e || w ? 16'h0000 : {b ? 8'h00 : mem[i1], mem[i0]};
    go_resp = (state == IDLE && req && WAIT_CYCLES == 0) || (state == WAIT && cnt == WL);
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      cw <= 1'b0;
      cb <= 1'b0;
      ca <= '0;
      cd <= '0;
      read_data <= '0;
      ready <= 1'b0;
      busy <= 1'b0;
      err <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      ready <= 1'b0;
      err <= 1'b0;
      if (state == IDLE && req) begin
        cw <= mem_write;
        cb <= byte_en;
        ca <= address;
        cd <= write_data;
        cnt <= '0;
        busy <= 1'b1;
      end
      if (state == RESP) begin
        state <= IDLE;
        busy <= 1'b0;
      end else if (go_resp) begin
        state <= RESP;
        ready <= 1'b1;
        err <= e;
        read_data <= rd;
        if (w && !e) begin
          mem[i0] <= d[7:0];
          if (!b) mem[i1] <= d[15:8];
        end
      end else if (state == IDLE && req) begin
        state <= WAIT;
      end else if (state == WAIT) begin
        cnt <= cnt + 4'd1;
      end
    end
  end
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed checks of two instances (2 and 0 wait states) against a per-cycle transaction model
module tb_mem_responder;
  logic clock = 0, reset = 0;
  logic req_v[2], wr_v[2], be_v[2];
  logic [15:0] addr_v[2], wd_v[2], rd_o[2];
  logic rdy[2], bsy[2], er[2];
  int n_cmp = 0, n_bad = 0;
  always #5 clock = ~clock;

  mem_responder #(.DEPTH(256), .WAIT_CYCLES(2)) d2 (
    .clock(clock), .reset(reset), .req(req_v[0]), .mem_write(wr_v[0]), .byte_en(be_v[0]),
    .address(addr_v[0]), .write_data(wd_v[0]), .read_data(rd_o[0]), .ready(rdy[0]), .busy(bsy[0]), .err(er[0]));
  mem_responder #(.DEPTH(256), .WAIT_CYCLES(0)) d0 (
    .clock(clock), .reset(reset), .req(req_v[1]), .mem_write(wr_v[1]), .byte_en(be_v[1]),
    .address(addr_v[1]), .write_data(wd_v[1]), .read_data(rd_o[1]), .ready(rdy[1]), .busy(bsy[1]), .err(er[1]));

  task automatic chk(input string nm, input int k, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %h want %h at %0t", nm, k, act, exp, $time);
    end
  endtask

  // Transaction model: rem = cycles the access still occupies; the response shows when rem == 1
  logic [7:0] mm [2][256];
  int rem[2], pa[2];
  logic [15:0] prd[2], shrd[2], pwd[2];
  logic pe[2], pw[2], pb[2];
  always @(posedge clock or posedge reset) begin
    int a;
    logic e, b, w;
    if (reset) begin
      for (int k = 0; k < 2; k++) begin
        rem[k] = 0; shrd[k] = 0; pe[k] = 0; pw[k] = 0;
        for (int j = 0; j < 256; j++) mm[k][j] = 8'h00;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (rem[k] == 0) begin
          if (req_v[k]) begin
            a = int'(addr_v[k]); b = be_v[k]; w = wr_v[k];
            e = (!b && a % 2 == 1) || a >= 256 || (!b && a + 1 >= 256);
            pe[k] = e; pw[k] = w && !e; pb[k] = b; pa[k] = a; pwd[k] = wd_v[k];
            prd[k] = 16'h0000;
            if (!e && !w) prd[k] = b ? {8'h00, mm[k][a]} : {mm[k][a + 1], mm[k][a]};
            rem[k] = (k == 0 ? 2 : 0) + 1;
          end
        end else rem[k]--;
        if (rem[k] == 1) begin
          shrd[k] = prd[k];
          if (pw[k]) begin
            mm[k][pa[k]] = pwd[k][7:0];
            if (!pb[k]) mm[k][pa[k] + 1] = pwd[k][15:8];
          end
        end
      end
    end
  end

  always @(negedge clock) begin
    for (int k = 0; k < 2; k++) begin
      chk("ready", k, 16'(rdy[k]), 16'(rem[k] == 1));
      chk("busy", k, 16'(bsy[k]), 16'(rem[k] > 0));
      chk("err", k, 16'(er[k]), 16'(rem[k] == 1 && pe[k]));
      chk("read_data", k, rd_o[k], shrd[k]);
    end
  end

  task automatic acc(input int k, input logic w, input logic b, input logic [15:0] a, input logic [15:0] d,
                     output logic [15:0] r, output logic e, output int lat);
    @(negedge clock);
    req_v[k] = 1; wr_v[k] = w; be_v[k] = b; addr_v[k] = a; wd_v[k] = d;
    @(negedge clock);
    req_v[k] = 0; wr_v[k] = ~w; be_v[k] = ~b; addr_v[k] = 16'h5555; wd_v[k] = 16'hFFFF;
    lat = 1;
    while (!rdy[k] && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    if (lat >= 20) chk("timeout", k, 16'(lat), 16'd0);
    r = rd_o[k];
    e = er[k];
  endtask

  logic [15:0] r;
  logic e;
  int lat, cnt;
  initial begin
    for (int k = 0; k < 2; k++) begin
      req_v[k] = 0; wr_v[k] = 0; be_v[k] = 0; addr_v[k] = 0; wd_v[k] = 0;
    end
    #1 reset = 1;
    repeat (2) @(negedge clock);
    chk("rst_rd", 0, rd_o[0], 16'h0000);
    chk("rst_busy", 0, 16'(bsy[0]), 16'h0000);
    reset = 0;
    acc(0, 1, 0, 16'h0010, 16'hBEEF, r, e, lat);
    chk("wr_lat", 0, 16'(lat), 16'd3);
    chk("wr_rd", 0, r, 16'h0000);
    acc(0, 0, 0, 16'h0010, 16'h0000, r, e, lat);
    chk("rd_lat", 0, 16'(lat), 16'd3);
    chk("rd_beef", 0, r, 16'hBEEF);
    chk("rd_err", 0, 16'(e), 16'h0000);
    acc(0, 1, 1, 16'h0011, 16'h005A, r, e, lat);
    acc(0, 0, 1, 16'h0011, 16'h0000, r, e, lat);
    chk("byte_rd", 0, r, 16'h005A);
    acc(0, 0, 0, 16'h0010, 16'h0000, r, e, lat);
    chk("merge_rd", 0, r, 16'h5AEF);
    acc(0, 0, 0, 16'h0003, 16'h0000, r, e, lat);
    chk("odd_err", 0, 16'(e), 16'h0001);
    chk("odd_rd", 0, r, 16'h0000);
    acc(0, 1, 1, 16'h0100, 16'h0077, r, e, lat);
    chk("oob_err", 0, 16'(e), 16'h0001);
    acc(0, 0, 0, 16'h0010, 16'h0000, r, e, lat);
    chk("unchanged", 0, r, 16'h5AEF);
    acc(0, 1, 0, 16'h00FE, 16'h1234, r, e, lat);
    chk("top_wr_err", 0, 16'(e), 16'h0000);
    acc(0, 0, 0, 16'h00FE, 16'h0000, r, e, lat);
    chk("top_rd", 0, r, 16'h1234);
    acc(0, 0, 0, 16'h00FF, 16'h0000, r, e, lat);
    chk("ff_word_err", 0, 16'(e), 16'h0001);
    acc(0, 0, 1, 16'h00FF, 16'h0000, r, e, lat);
    chk("ff_byte", 0, r, 16'h0012);
    acc(0, 0, 1, 16'hFFFF, 16'h0000, r, e, lat);
    chk("ffff_err", 0, 16'(e), 16'h0001);
    acc(1, 1, 0, 16'h0040, 16'hCAFE, r, e, lat);
    acc(1, 0, 0, 16'h0040, 16'h0000, r, e, lat);
    chk("w0_lat", 1, 16'(lat), 16'd1);
    chk("w0_rd", 1, r, 16'hCAFE);
    // Continuous req with no wait states: one response every second cycle
    @(negedge clock);
    req_v[1] = 1; wr_v[1] = 0; be_v[1] = 0; addr_v[1] = 16'h0040;
    cnt = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clock);
      cnt += int'(rdy[1]);
    end
    req_v[1] = 0;
    chk("stream_rdy", 1, 16'(cnt), 16'd4);
    // req pulses while busy must not produce extra responses
    @(negedge clock);
    req_v[0] = 1; wr_v[0] = 0; be_v[0] = 1; addr_v[0] = 16'h0011;
    cnt = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clock);
      cnt += int'(rdy[0]);
      req_v[0] = (i == 1 || i == 3);
    end
    chk("pulse_rdy", 0, 16'(cnt), 16'd1);
    // Reset in the middle of a write's wait states
    @(negedge clock);
    req_v[0] = 1; wr_v[0] = 1; be_v[0] = 0; addr_v[0] = 16'h0020; wd_v[0] = 16'hA5A5;
    @(negedge clock);
    req_v[0] = 0;
    #2 reset = 1;
    #1;
    chk("arst_busy", 0, 16'(bsy[0]), 16'h0000);
    chk("arst_rdy", 0, 16'(rdy[0]), 16'h0000);
    chk("arst_rd", 0, rd_o[0], 16'h0000);
    @(negedge clock);
    reset = 0;
    cnt = 0;
    repeat (5) begin
      @(negedge clock);
      cnt += int'(rdy[0]);
    end
    chk("arst_no_rdy", 0, 16'(cnt), 16'd0);
    acc(0, 0, 0, 16'h0020, 16'h0000, r, e, lat);
    chk("discarded", 0, r, 16'h0000);
    acc(0, 0, 0, 16'h0010, 16'h0000, r, e, lat);
    chk("cleared", 0, r, 16'h0000);
    @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
